// File: rtl/arc_pkg.sv
// Shared ARC datapath definitions: ALU opcodes, microinstruction layout and special register indices.
// The control store and the datapath both import this package.
package arc_pkg;

  localparam int DATA_W    = 32;
  localparam int MIR_W     = 41;
  localparam int REG_IDX_W = 6;
  localparam int NUM_REGS  = 38;

  localparam logic [5:0] REG_R0    = 6'd0;
  localparam logic [5:0] REG_PC    = 6'd32;
  localparam logic [5:0] REG_TEMP0 = 6'd33;
  localparam logic [5:0] REG_TEMP1 = 6'd34;
  localparam logic [5:0] REG_TEMP2 = 6'd35;
  localparam logic [5:0] REG_TEMP3 = 6'd36;
  localparam logic [5:0] REG_IR    = 6'd37;
  localparam logic [5:0] REG_COUNT = 6'd38;

  localparam int MIR_A_HI    = 40;
  localparam int MIR_A_LO    = 35;
  localparam int MIR_AMUX    = 34;
  localparam int MIR_B_HI    = 33;
  localparam int MIR_B_LO    = 28;
  localparam int MIR_BMUX    = 27;
  localparam int MIR_C_HI    = 26;
  localparam int MIR_C_LO    = 21;
  localparam int MIR_CMUX    = 20;
  localparam int MIR_RD      = 19;
  localparam int MIR_WR      = 18;
  localparam int MIR_ALU_HI  = 17;
  localparam int MIR_ALU_LO  = 14;
  localparam int MIR_COND_HI = 13;
  localparam int MIR_COND_LO = 11;
  localparam int MIR_JADDR_HI = 10;
  localparam int MIR_JADDR_LO = 0;

  // Register-field positions inside %ir used when the AMUX/BMUX/CMUX selects are set.
  localparam int IR_RS1_HI = 18;
  localparam int IR_RS1_LO = 14;
  localparam int IR_RS2_HI = 4;
  localparam int IR_RS2_LO = 0;
  localparam int IR_RD_HI  = 29;
  localparam int IR_RD_LO  = 25;

  typedef enum logic [3:0] {
    ALU_ANDCC    = 4'd0,
    ALU_ORCC     = 4'd1,
    ALU_NORCC    = 4'd2,
    ALU_ADDCC    = 4'd3,
    ALU_SRL      = 4'd4,
    ALU_AND      = 4'd5,
    ALU_OR       = 4'd6,
    ALU_NOR      = 4'd7,
    ALU_ADD      = 4'd8,
    ALU_LSHIFT2  = 4'd9,
    ALU_LSHIFT10 = 4'd10,
    ALU_SIMM13   = 4'd11,
    ALU_SEXT13   = 4'd12,
    ALU_INC      = 4'd13,
    ALU_INCPC    = 4'd14,
    ALU_RSHIFT5  = 4'd15
  } alu_op_e;

  // Field order matches the MIR bit positions above, MSB first.
  typedef struct packed {
    logic [5:0]  a;
    logic        amux;
    logic [5:0]  b;
    logic        bmux;
    logic [5:0]  c;
    logic        cmux;
    logic        rd;
    logic        wr;
    alu_op_e     alu;
    logic [2:0]  cond;
    logic [10:0] jaddr;
  } mir_t;

  function automatic logic regValid(input logic [5:0] idx);
    return (idx != REG_R0) && (idx < REG_COUNT);
  endfunction

  function automatic logic aluSetsFlags(input alu_op_e op);
    return (op == ALU_ANDCC) || (op == ALU_ORCC) || (op == ALU_NORCC) || (op == ALU_ADDCC);
  endfunction

endpackage

// File: rtl/arc_alu.sv
// Combinational ARC ALU: sixteen operations plus n/z/v/c flag generation.
// Flags are always produced; the datapath decides whether to latch them.
module arc_alu
  import arc_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_result,
  output logic        o_n,
  output logic        o_z,
  output logic        o_v,
  output logic        o_c
);

  logic [32:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  always_comb begin
    o_result = 32'd0;
    case (i_op)
      ALU_ANDCC, ALU_AND: o_result = i_a & i_b;
      ALU_ORCC,  ALU_OR:  o_result = i_a | i_b;
      ALU_NORCC, ALU_NOR: o_result = ~(i_a | i_b);
      ALU_ADDCC, ALU_ADD: o_result = w_sum[31:0];
      ALU_SRL:            o_result = i_a >> i_b[4:0];
      ALU_LSHIFT2:        o_result = i_a << 2;
      ALU_LSHIFT10:       o_result = i_a << 10;
      ALU_SIMM13:         o_result = {19'd0, i_a[12:0]};
      ALU_SEXT13:         o_result = {{19{i_a[12]}}, i_a[12:0]};
      ALU_INC:            o_result = i_a + 32'd1;
      ALU_INCPC:          o_result = i_a + 32'd4;
      ALU_RSHIFT5:        o_result = 32'($signed(i_a) >>> 5);
      default:            o_result = 32'd0;
    endcase
  end

  // Only ADDCC produces carry/overflow; the logical cc ops report them as zero.
  always_comb begin
    o_n = o_result[31];
    o_z = (o_result == 32'd0);
    o_v = 1'b0;
    o_c = 1'b0;
    if (i_op == ALU_ADDCC) begin
      o_c = w_sum[32];
      o_v = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
    end
  end

endmodule

// File: rtl/datapath_section.sv
// ARC datapath: 38-entry register file, A/B/C bus steering, ALU and PSR.
// Everything is driven directly by the current microinstruction; no bypass from C to A/B.
module datapath_section
  import arc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [40:0] mir,
  output logic [31:0] ir,
  output logic [3:0]  psr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  logic [31:0] r_regs [0:NUM_REGS-1];
  logic [3:0]  r_psr;

  mir_t        w_mir;
  logic [5:0]  w_aIdx;
  logic [5:0]  w_bIdx;
  logic [5:0]  w_cIdx;
  logic [31:0] w_aBus;
  logic [31:0] w_bBus;
  logic [31:0] w_cBus;
  logic [31:0] w_irReg;
  logic [31:0] w_aluResult;
  logic        w_aluN;
  logic        w_aluZ;
  logic        w_aluV;
  logic        w_aluC;
  logic        w_unusedMirBits;

  assign w_mir           = mir_t'(mir);
  assign w_unusedMirBits = ^{w_mir.cond, w_mir.jaddr};
  assign w_irReg         = r_regs[REG_IR];

  // Operand/destination selection: either the MIR fields or the register fields of %ir.
  always_comb begin
    w_aIdx = w_mir.a;
    w_bIdx = w_mir.b;
    w_cIdx = w_mir.c;
    if (w_mir.amux) w_aIdx = {1'b0, w_irReg[IR_RS1_HI:IR_RS1_LO]};
    if (w_mir.bmux) w_bIdx = {1'b0, w_irReg[IR_RS2_HI:IR_RS2_LO]};
    if (w_mir.cmux) w_cIdx = {1'b0, w_irReg[IR_RD_HI:IR_RD_LO]};
  end

  always_comb begin
    w_aBus = 32'd0;
    w_bBus = 32'd0;
    if (regValid(w_aIdx)) w_aBus = r_regs[w_aIdx];
    if (regValid(w_bIdx)) w_bBus = r_regs[w_bIdx];
  end

  arc_alu u_alu (
    .i_a      (w_aBus),
    .i_b      (w_bBus),
    .i_op     (w_mir.alu),
    .o_result (w_aluResult),
    .o_n      (w_aluN),
    .o_z      (w_aluZ),
    .o_v      (w_aluV),
    .o_c      (w_aluC)
  );

  assign w_cBus = w_mir.rd ? mem_rdata : w_aluResult;

  // Flags never follow memory data, so a read cycle leaves the PSR alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
      r_psr <= 4'd0;
    end else begin
      if (regValid(w_cIdx)) r_regs[w_cIdx] <= w_cBus;
      if (!w_mir.rd && aluSetsFlags(w_mir.alu)) r_psr <= {w_aluN, w_aluZ, w_aluV, w_aluC};
    end
  end

  assign ir        = w_irReg;
  assign psr       = r_psr;
  assign mem_addr  = w_aBus;
  assign mem_wdata = w_bBus;
  assign mem_rd    = w_mir.rd;
  assign mem_wr    = w_mir.wr;

endmodule

// File: tb/tb_datapath_section.sv
// Self-checking bench for datapath_section: reference model plus scoreboard of register writes,
// read back through the A bus (mem_addr).
module tb_datapath_section;

  logic        clk;
  logic        rst;
  logic [40:0] mir;
  logic [31:0] ir;
  logic [3:0]  psr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  int errCount   = 0;
  int checkCount = 0;

  logic [31:0] mRegs [0:63];
  logic [3:0]  mPsr;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] val;
  } expEntry_t;

  expEntry_t sbQueue[$];

  datapath_section dut (
    .clk       (clk),
    .rst       (rst),
    .mir       (mir),
    .ir        (ir),
    .psr       (psr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [40:0] mk(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                                     input logic amux, input logic bmux, input logic cmux,
                                     input logic rd, input logic wr, input logic [3:0] alu);
    return {a, amux, b, bmux, c, cmux, rd, wr, alu, 14'd0};
  endfunction

  function automatic logic [31:0] mRead(input logic [5:0] idx);
    if (idx == 6'd0 || idx > 6'd37) return 32'd0;
    return mRegs[idx];
  endfunction

  // Reference ALU, written from the opcode table; flags returned as {n,z,v,c}.
  task automatic tbAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [3:0] fl);
    logic [63:0] s64;
    logic        v;
    logic        c;
    s64 = {32'd0, a} + {32'd0, b};
    v = 1'b0;
    c = 1'b0;
    case (op)
      4'd0, 4'd5:  res = a & b;
      4'd1, 4'd6:  res = a | b;
      4'd2, 4'd7:  res = ~(a | b);
      4'd3, 4'd8:  res = s64[31:0];
      4'd4:        res = a >> b[4:0];
      4'd9:        res = {a[29:0], 2'b00};
      4'd10:       res = {a[21:0], 10'd0};
      4'd11:       res = {19'd0, a[12:0]};
      4'd12:       res = {{19{a[12]}}, a[12:0]};
      4'd13:       res = a + 32'd1;
      4'd14:       res = a + 32'd4;
      default:     res = {{5{a[31]}}, a[31:5]};
    endcase
    if (op == 4'd3) begin
      c = s64[32];
      v = (a[31] & b[31] & ~res[31]) | (~a[31] & ~b[31] & res[31]);
    end
    fl = {res[31], (res == 32'd0), v, c};
  endtask

  task automatic readReg(input logic [5:0] idx, output logic [31:0] val);
    @(negedge clk);
    mir = mk(idx, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    mem_rdata = 32'd0;
    #1 val = mem_addr;
  endtask

  task automatic expectReg(input string tag, input logic [5:0] idx, input logic [31:0] val);
    logic [31:0] got;
    readReg(idx, got);
    checkOutput(tag, got, val);
  endtask

  task automatic applyStimulus(input logic [40:0] m, input logic [31:0] rdata);
    logic [5:0]  ai, bi, ci;
    logic [31:0] a, b, res, cbus, got;
    logic [3:0]  fl;
    expEntry_t   e;
    ai = m[34] ? {1'b0, mRegs[37][18:14]} : m[40:35];
    bi = m[27] ? {1'b0, mRegs[37][4:0]}   : m[33:28];
    ci = m[20] ? {1'b0, mRegs[37][29:25]} : m[26:21];
    a = mRead(ai);
    b = mRead(bi);
    tbAlu(m[17:14], a, b, res, fl);
    cbus = m[19] ? rdata : res;
    @(negedge clk);
    mir = m;
    mem_rdata = rdata;
    #1;
    checkOutput("memAddr", mem_addr, a);
    checkOutput("memWdata", mem_wdata, b);
    checkOutput("strobes", {30'd0, mem_rd, mem_wr}, {30'd0, m[19], m[18]});
    @(posedge clk);
    #1;
    if (!m[19] && m[17:14] <= 4'd3) mPsr = fl;
    if (ci != 6'd0 && ci < 6'd38) begin
      mRegs[ci] = cbus;
      sbQueue.push_back('{ci, cbus});
    end
    checkOutput("psr", {28'd0, psr}, {28'd0, mPsr});
    checkOutput("ir", ir, mRegs[37]);
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      readReg(e.idx, got);
      checkOutput("regfile", got, e.val);
    end
  endtask

  task automatic loadReg(input logic [5:0] idx, input logic [31:0] val);
    applyStimulus(mk(6'd0, 6'd0, idx, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3), val);
  endtask

  // Reset with a write-and-flag request on mir to confirm reset suppresses it.
  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    mir = mk(6'd0, 6'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    mem_rdata = 32'h1234_5678;
    #1 checkOutput("rstStrobe", {30'd0, mem_rd, mem_wr}, 32'd3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mir = '0;
    for (int i = 0; i < 64; i++) mRegs[i] = 32'd0;
    mPsr = 4'd0;
    #1;
    checkOutput("rstPsr", {28'd0, psr}, 32'd0);
    checkOutput("rstIr", ir, 32'd0);
    expectReg("rstPc", 6'd32, 32'd0);
    expectReg("rstR1", 6'd1, 32'd0);
  endtask

  initial begin
    logic [3:0] savedPsr;
    rst = 1'b1;
    mir = '0;
    mem_rdata = '0;
    mPsr = 4'd0;
    for (int i = 0; i < 64; i++) mRegs[i] = 32'd0;

    resetDut();

    $display("[TB] zero add sets z");
    applyStimulus(mk(6'd0, 6'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3), 32'd0);
    checkOutput("zeroAddPsr", {28'd0, psr}, 32'h4);
    expectReg("zeroAddR1", 6'd1, 32'd0);

    $display("[TB] signed overflow");
    loadReg(6'd1, 32'h7FFF_FFFF);
    loadReg(6'd2, 32'd1);
    applyStimulus(mk(6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3), 32'd0);
    expectReg("ovfR3", 6'd3, 32'h8000_0000);
    checkOutput("ovfPsr", {28'd0, psr}, 32'hA);
    applyStimulus(mk(6'd1, 6'd2, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8), 32'd0);
    checkOutput("addHoldsPsr", {28'd0, psr}, 32'hA);

    $display("[TB] carry out");
    loadReg(6'd1, 32'hFFFF_FFFF);
    applyStimulus(mk(6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3), 32'd0);
    expectReg("carryR3", 6'd3, 32'd0);
    checkOutput("carryPsr", {28'd0, psr}, 32'h5);

    $display("[TB] instruction fetch into ir");
    loadReg(6'd32, 32'h100);
    savedPsr = psr;
    applyStimulus(mk(6'd32, 6'd0, 6'd37, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3), 32'h8A00_4002);
    checkOutput("fetchIr", ir, 32'h8A00_4002);
    checkOutput("fetchPsr", {28'd0, psr}, {28'd0, savedPsr});

    $display("[TB] ir-directed operands and r0");
    loadReg(6'd1, 32'd5);
    loadReg(6'd2, 32'd7);
    applyStimulus(mk(6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8), 32'd0);
    expectReg("irAddR5", 6'd5, 32'd12);
    applyStimulus(mk(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8), 32'h0000_DEAD);
    expectReg("r0Zero", 6'd0, 32'd0);
    applyStimulus(mk(6'd0, 6'd0, 6'd40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8), 32'h0000_BEEF);
    expectReg("r40Zero", 6'd40, 32'd0);

    $display("[TB] immediates and shifts");
    loadReg(6'd1, 32'h0000_1FFF);
    savedPsr = psr;
    applyStimulus(mk(6'd1, 6'd0, 6'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12), 32'd0);
    expectReg("sext13", 6'd6, 32'hFFFF_FFFF);
    applyStimulus(mk(6'd1, 6'd0, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11), 32'd0);
    expectReg("simm13", 6'd7, 32'h0000_1FFF);
    loadReg(6'd1, 32'h8000_0000);
    applyStimulus(mk(6'd1, 6'd0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15), 32'd0);
    expectReg("rshift5", 6'd8, 32'hFC00_0000);
    loadReg(6'd1, 32'hFFFF_FFFC);
    applyStimulus(mk(6'd1, 6'd0, 6'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd14), 32'd0);
    expectReg("incpcWrap", 6'd9, 32'd0);
    checkOutput("incpcPsr", {28'd0, psr}, {28'd0, savedPsr});

    $display("[TB] random microinstructions");
    for (int i = 0; i < 60; i++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      applyStimulus(r[40:0], $urandom());
    end

    resetDut();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
